// File: rtl/cam_capture_ctrl.sv
// OV7670 capture sequencer: synchronizes the camera bus, packs RGB565 byte pairs into RGB332
// and writes the 176x144 frame buffer. Optional test pattern source: define TEST_PATTERN_EN.
module cam_capture_ctrl #(
  parameter int SCREEN_WIDTH  = 176,
  parameter int SCREEN_HEIGHT = 144,
  parameter int ADDR_W        = 15
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              CAM_PCLK,
  input  logic              CAM_HREF,
  input  logic              CAM_VSYNC,
  input  logic [7:0]        CAM_DATA,
  input  logic              START,
  input  logic              CONTINUOUS,
  input  logic              TEST_MODE,
  output logic [ADDR_W-1:0] W_ADDR,
  output logic [7:0]        W_DATA,
  output logic              W_EN,
  output logic              BUSY,
  output logic              FRAME_DONE,
  output logic              LINE_ERR
);

  localparam int XW = $clog2(SCREEN_WIDTH + 1);
  localparam int YW = $clog2(SCREEN_HEIGHT + 1);
  localparam logic [XW-1:0] LP_X_MAX = XW'(SCREEN_WIDTH);
  localparam logic [YW-1:0] LP_Y_MAX = YW'(SCREEN_HEIGHT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_CAPT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  logic              r_pclk_s1, r_pclk_s2, r_pclk_s3;
  logic              r_href_s1, r_href_s2, r_href_d;
  logic              r_vsync_s1, r_vsync_s2, r_vsync_d;
  logic [7:0]        r_data_s1, r_data_s2;
  logic [XW-1:0]     r_x, w_x_nxt;
  logic [YW-1:0]     r_y, w_y_nxt;
  logic              r_phase, w_phase_nxt;
  logic [7:0]        r_byte_a, w_byte_a_nxt;
  logic [ADDR_W-1:0] r_w_addr, w_waddr_nxt, w_addr_calc;
  logic [7:0]        r_w_data, w_wdata_nxt, w_pixel;
  logic              r_w_en, w_wen_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_frame_done, w_done_nxt;
  logic              r_line_err, w_lerr_nxt;
  logic              w_pclk_rise, w_href_fall, w_vsync_fall, w_vsync_rise, w_byte_valid;

  function automatic logic [7:0] f_rgb565_to_332(input logic [7:0] a, input logic [7:0] b);
    return {a[7:5], a[2:0], b[4:3]};
  endfunction

  assign w_pclk_rise  = r_pclk_s2 & ~r_pclk_s3;
  assign w_href_fall  = r_href_d & ~r_href_s2;
  assign w_vsync_fall = r_vsync_d & ~r_vsync_s2;
  assign w_vsync_rise = ~r_vsync_d & r_vsync_s2;
  // A byte clocked together with the HREF fall still belongs to the ending line.
  assign w_byte_valid = w_pclk_rise & (r_href_s2 | w_href_fall);
  assign w_addr_calc  = ADDR_W'(r_y) * ADDR_W'(SCREEN_WIDTH) + ADDR_W'(r_x);

`ifdef TEST_PATTERN_EN
  always_comb begin
    if (TEST_MODE) begin
      if ((32'(r_x) >= 32'd80 && 32'(r_x) <= 32'd96) || (32'(r_y) >= 32'd64 && 32'(r_y) <= 32'd80)) begin
        w_pixel = 8'b111_000_00;
      end else begin
        w_pixel = 8'b111_111_11;
      end
    end else begin
      w_pixel = f_rgb565_to_332(r_byte_a, r_data_s2);
    end
  end
`else
  logic w_unused_test_mode;
  assign w_unused_test_mode = TEST_MODE;
  assign w_pixel = f_rgb565_to_332(r_byte_a, r_data_s2);
`endif

  // Frame sequencing: next state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = START ? S_WAIT : S_IDLE;
      S_WAIT:  w_state_nxt = w_vsync_fall ? S_CAPT : S_WAIT;
      S_CAPT:  w_state_nxt = w_vsync_rise ? S_DONE : S_CAPT;
      S_DONE:  w_state_nxt = CONTINUOUS ? S_WAIT : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Status outputs decoded from the upcoming state so the flops line up with it.
  always_comb begin
    w_busy_nxt = 1'b0;
    w_done_nxt = 1'b0;
    case (w_state_nxt)
      S_IDLE:  begin w_busy_nxt = 1'b0; w_done_nxt = 1'b0; end
      S_WAIT:  begin w_busy_nxt = 1'b1; w_done_nxt = 1'b0; end
      S_CAPT:  begin w_busy_nxt = 1'b1; w_done_nxt = 1'b0; end
      S_DONE:  begin w_busy_nxt = 1'b1; w_done_nxt = 1'b1; end
      default: begin w_busy_nxt = 1'b0; w_done_nxt = 1'b0; end
    endcase
  end

  // Pixel assembly and line bookkeeping; byte handling first, then line-end rules.
  always_comb begin
    w_x_nxt      = r_x;
    w_y_nxt      = r_y;
    w_phase_nxt  = r_phase;
    w_byte_a_nxt = r_byte_a;
    w_wen_nxt    = 1'b0;
    w_wdata_nxt  = r_w_data;
    w_waddr_nxt  = r_w_addr;
    w_lerr_nxt   = r_line_err;
    case (r_state)
      S_IDLE: begin
        if (START) begin
          w_lerr_nxt = 1'b0;
        end else begin
          w_lerr_nxt = r_line_err;
        end
      end
      S_WAIT: begin
        if (w_vsync_fall) begin
          w_x_nxt     = {XW{1'b0}};
          w_y_nxt     = {YW{1'b0}};
          w_phase_nxt = 1'b0;
        end else begin
          w_phase_nxt = r_phase;
        end
      end
      S_CAPT: begin
        if (w_byte_valid) begin
          if (!r_phase) begin
            w_byte_a_nxt = r_data_s2;
            w_phase_nxt  = 1'b1;
          end else begin
            w_phase_nxt = 1'b0;
            if (r_x < LP_X_MAX && r_y < LP_Y_MAX) begin
              w_wen_nxt   = 1'b1;
              w_wdata_nxt = w_pixel;
              w_waddr_nxt = w_addr_calc;
            end else begin
              w_wen_nxt = 1'b0;
            end
            if (r_x < LP_X_MAX) begin
              w_x_nxt = r_x + XW'(1'b1);
            end else begin
              w_x_nxt = r_x;
            end
          end
        end else begin
          w_wen_nxt = 1'b0;
        end
        if (w_href_fall) begin
          if (w_phase_nxt) begin
            w_lerr_nxt = 1'b1;
          end else begin
            w_lerr_nxt = r_line_err;
          end
          if (w_x_nxt != {XW{1'b0}} && r_y < LP_Y_MAX) begin
            w_y_nxt = r_y + YW'(1'b1);
          end else begin
            w_y_nxt = r_y;
          end
          w_x_nxt     = {XW{1'b0}};
          w_phase_nxt = 1'b0;
        end else begin
          w_lerr_nxt = r_line_err;
        end
      end
      default: w_wen_nxt = 1'b0;
    endcase
  end

  // All state, including the input synchronizers, with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_state      <= S_IDLE;
      {r_pclk_s1, r_pclk_s2, r_pclk_s3}   <= 3'b000;
      {r_href_s1, r_href_s2, r_href_d}    <= 3'b000;
      {r_vsync_s1, r_vsync_s2, r_vsync_d} <= 3'b000;
      r_data_s1    <= 8'd0;
      r_data_s2    <= 8'd0;
      r_x          <= {XW{1'b0}};
      r_y          <= {YW{1'b0}};
      r_phase      <= 1'b0;
      r_byte_a     <= 8'd0;
      r_w_addr     <= {ADDR_W{1'b0}};
      r_w_data     <= 8'd0;
      r_w_en       <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_line_err   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      {r_pclk_s1, r_pclk_s2, r_pclk_s3}   <= {CAM_PCLK, r_pclk_s1, r_pclk_s2};
      {r_href_s1, r_href_s2, r_href_d}    <= {CAM_HREF, r_href_s1, r_href_s2};
      {r_vsync_s1, r_vsync_s2, r_vsync_d} <= {CAM_VSYNC, r_vsync_s1, r_vsync_s2};
      r_data_s1    <= CAM_DATA;
      r_data_s2    <= r_data_s1;
      r_x          <= w_x_nxt;
      r_y          <= w_y_nxt;
      r_phase      <= w_phase_nxt;
      r_byte_a     <= w_byte_a_nxt;
      r_w_addr     <= w_waddr_nxt;
      r_w_data     <= w_wdata_nxt;
      r_w_en       <= w_wen_nxt;
      r_busy       <= w_busy_nxt;
      r_frame_done <= w_done_nxt;
      r_line_err   <= w_lerr_nxt;
    end
  end

  assign W_ADDR     = r_w_addr;
  assign W_DATA     = r_w_data;
  assign W_EN       = r_w_en;
  assign BUSY       = r_busy;
  assign FRAME_DONE = r_frame_done;
  assign LINE_ERR   = r_line_err;

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Randomized directed bench for cam_capture_ctrl on a reduced 24x6 screen; expected writes
// come from a frame-level model of the line/pixel rules.
module tb_cam_capture_ctrl;
  localparam int W  = 24;
  localparam int H  = 6;
  localparam int AW = 15;

  logic clk = 1'b0, rst_n = 1'b0;
  logic pclk = 1'b0, href = 1'b0, vsync = 1'b1;
  logic [7:0] cdata = 8'd0;
  logic start = 1'b0, cont = 1'b0, tmode = 1'b0;
  wire [AW-1:0] w_addr;
  wire [7:0] w_data;
  wire w_en, busy, fdone, lerr;

  always #5 clk = ~clk;

  cam_capture_ctrl #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .ADDR_W(AW)) dut (
    .CLK(clk), .RESET_N(rst_n), .CAM_PCLK(pclk), .CAM_HREF(href), .CAM_VSYNC(vsync),
    .CAM_DATA(cdata), .START(start), .CONTINUOUS(cont), .TEST_MODE(tmode),
    .W_ADDR(w_addr), .W_DATA(w_data), .W_EN(w_en), .BUSY(busy),
    .FRAME_DONE(fdone), .LINE_ERR(lerr)
  );

  int n_total = 0, n_pass = 0, n_fail = 0;
  int exp_addr[$];
  logic [7:0] exp_data[$];
  int wr_cnt = 0, done_cnt = 0, busy_low = 0, last_addr = 0;
  bit mon_en = 1'b0, cont_win = 1'b0;
  logic prev_wen = 1'b0;
  int mdl_y = 0, mdl_pushed = 0;
  bit mdl_lerr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_total++;
    assert (obs === want) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // Write monitor: every strobe is matched against the model queue.
  always @(negedge clk) begin
    if (w_en === 1'b1) begin
      wr_cnt++;
      chk("wen_not_back_to_back", prev_wen, 32'd0);
      if (mon_en) begin
        chk("write_expected", exp_addr.size() > 0, 32'd1);
        if (exp_addr.size() > 0) begin
          chk("w_addr", w_addr, exp_addr.pop_front());
          chk("w_data", w_data, exp_data.pop_front());
        end
      end
      last_addr = int'(w_addr);
    end
    if (fdone === 1'b1) done_cnt++;
    if (cont_win && busy !== 1'b1) busy_low++;
    prev_wen = w_en;
  end

  task automatic push_pixel(input logic [7:0] a, input logic [7:0] b, input int k);
    logic [7:0] d;
    if (k < W && mdl_y < H) begin
      d = (a & 8'hE0) | ((a & 8'h07) << 2) | ((b >> 3) & 8'h03);
`ifdef TEST_PATTERN_EN
      if (tmode) d = ((k >= 80 && k <= 96) || (mdl_y >= 64 && mdl_y <= 80)) ? 8'hE0 : 8'hFF;
`endif
      exp_addr.push_back(mdl_y * W + k);
      exp_data.push_back(d);
      mdl_pushed++;
    end
  endtask

  task automatic send_line(input int n, input bit same_edge, input bit fixed);
    logic [7:0] a, b;
    a = 8'd0;
    href = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      b = fixed ? ((i % 2 == 0) ? 8'hF8 : 8'h1F) : 8'($urandom);
      cdata = b;
      repeat (2) @(negedge clk);
      if (same_edge && i == n - 1) href = 1'b0;
      pclk = 1'b1;
      if (i % 2 == 0) a = b;
      else push_pixel(a, b, i / 2);
      repeat (2) @(negedge clk);
      pclk = 1'b0;
    end
    if (!same_edge) begin
      repeat (2) @(negedge clk);
      href = 1'b0;
    end
    if (n % 2 == 1) mdl_lerr = 1'b1;
    if (n / 2 > 0 && mdl_y < H) mdl_y++;
    repeat (6) @(negedge clk);
  endtask

  task automatic do_frame(input int nl, input int nb, input int odd_idx, input int same_idx, input bit fixed);
    mdl_y = 0;
    mdl_pushed = 0;
    wr_cnt = 0;
    repeat (4) @(negedge clk);
    vsync = 1'b0;
    repeat (6) @(negedge clk);
    for (int l = 0; l < nl; l++) send_line((l == odd_idx) ? nb - 1 : nb, l == same_idx, fixed);
    vsync = 1'b1;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mdl_lerr = 1'b0;
    chk("busy_after_start", busy, 32'd1);
    chk("line_err_cleared", lerr, 32'd0);
  endtask

  task automatic wait_done(input bit busy_after);
    int t;
    t = 0;
    while (fdone !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("frame_done_seen", t < 100, 32'd1);
    chk("busy_during_done", busy, 32'd1);
    @(negedge clk);
    chk("frame_done_pulse", fdone, 32'd0);
    chk("busy_after_done", busy, 32'(busy_after));
    chk("writes_count", wr_cnt, mdl_pushed);
    chk("exp_queue_drained", exp_addr.size(), 32'd0);
    chk("line_err", lerr, 32'(mdl_lerr));
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with camera lines toggling.
    for (int i = 0; i < 8; i++) begin
      pclk = ~pclk;
      href = (i % 4) < 2;
      cdata = 8'($urandom);
      @(negedge clk);
    end
    chk("rst_w_addr", w_addr, 32'd0);
    chk("rst_w_data", w_data, 32'd0);
    chk("rst_w_en", w_en, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_frame_done", fdone, 32'd0);
    chk("rst_line_err", lerr, 32'd0);
    chk("rst_no_writes", wr_cnt, 32'd0);
    pclk = 1'b0;
    href = 1'b0;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_busy", busy, 32'd0);
    chk("idle_frame_done", fdone, 32'd0);
    mon_en = 1'b1;

    // Single frame with fixed bytes.
    do_start();
    do_frame(H, 2 * W, -1, -1, 1'b1);
    wait_done(1'b0);
    chk("frame_writes", wr_cnt, W * H);
    chk("last_addr", last_addr, W * H - 1);

    // Oversized lines and extra lines are clipped.
    do_start();
    do_frame(H + 2, 2 * W + 10, -1, -1, 1'b0);
    wait_done(1'b0);
    chk("clip_writes", wr_cnt, W * H);
    chk("clip_last_addr", last_addr, W * H - 1);

    // Odd-length line, plus a line whose last byte coincides with the HREF fall.
    do_start();
    do_frame(4, 2 * W, 1, 2, 1'b0);
    wait_done(1'b0);
    chk("odd_line_err_sticky", lerr, 32'd1);
    do_start();
    do_frame(2, 2 * W, -1, -1, 1'b0);
    wait_done(1'b0);

    // Continuous mode over two frames.
    cont = 1'b1;
    done_cnt = 0;
    busy_low = 0;
    do_start();
    cont_win = 1'b1;
    do_frame(2, 2 * W, -1, -1, 1'b0);
    wait_done(1'b1);
    repeat (3) @(negedge clk);
    chk("cont_busy_between", busy, 32'd1);
    cont = 1'b0;
    do_frame(2, 2 * W, -1, -1, 1'b0);
    cont_win = 1'b0;
    wait_done(1'b0);
    chk("cont_busy_held", busy_low, 32'd0);
    chk("cont_frames", done_cnt, 32'd2);

`ifdef TEST_PATTERN_EN
    tmode = 1'b1;
    do_start();
    do_frame(2, 2 * W, -1, -1, 1'b0);
    wait_done(1'b0);
    tmode = 1'b0;
`endif

    // Reset in the middle of a line.
    mon_en = 1'b0;
    do_start();
    repeat (4) @(negedge clk);
    vsync = 1'b0;
    repeat (6) @(negedge clk);
    wr_cnt = 0;
    href = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      cdata = 8'($urandom);
      repeat (2) @(negedge clk);
      pclk = 1'b1;
      repeat (2) @(negedge clk);
      pclk = 1'b0;
    end
    chk("abort_was_writing", wr_cnt > 0, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    wr_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      cdata = 8'($urandom);
      repeat (2) @(negedge clk);
      pclk = 1'b1;
      repeat (2) @(negedge clk);
      pclk = 1'b0;
    end
    chk("abort_no_wen", wr_cnt, 32'd0);
    chk("abort_busy", busy, 32'd0);
    chk("abort_w_addr", w_addr, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cdata = 8'($urandom);
      repeat (2) @(negedge clk);
      pclk = 1'b1;
      repeat (2) @(negedge clk);
      pclk = 1'b0;
    end
    href = 1'b0;
    vsync = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_abort_idle_no_wen", wr_cnt, 32'd0);
    chk("post_abort_busy", busy, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
